instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first instruction-memory byte address.
REQ-002 SHALL have parameter ERR_W, default 8, width of the error counter.
REQ-003 SHALL have port clk, input, 1, the only clock; rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid/in_ready, input/output, 1/1, field-bundle handshake.
REQ-006 SHALL have port in_fmt, input, 3, format: R=0 I=1 S=2 B=3 U=4 J=5; 6-7 illegal.
REQ-007 SHALL have ports in_opcode, input, 7; in_rd/in_rs1/in_rs2, input, 5 each; in_funct3, input, 3; in_funct7, input, 7.
REQ-008 SHALL have port in_imm, input, 32, signed byte-offset or value immediate.
REQ-009 SHALL have port out_valid/out_ready, output/input, 1/1, encoded-word handshake.
REQ-010 SHALL have ports out_instr, output, 32; out_addr, output, 32; out_err, output, 1 (head word flagged bad).
REQ-011 SHALL have ports clr_addr, input, 1, sync address reload; err_cnt, output, ERR_W.

Function
REQ-012 SHALL encode RV32I standard layouts: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-013 SHALL range-check: I/S imm[31:11] all equal; B imm[0]=0 and imm[31:12] all equal; U imm[11:0]=0; J imm[0]=0 and imm[31:20] all equal; R never errors.
REQ-014 SHALL on range fail still emit truncated encoding with out_err=1 for that word.
REQ-015 SHALL on illegal fmt emit 32'h0000_0013 (NOP) with out_err=1.
REQ-016 SHALL buffer encoded words {instr,err} in a 2-entry FIFO; in_ready = (count != 2), no combinational path from out_ready.
REQ-017 SHALL present a word on out_valid the cycle after acceptance when FIFO was empty (latency 1).
REQ-018 SHALL hold out_instr/out_err stable while out_valid=1 and out_ready=0.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; pop on empty and push on full are impossible by handshake.
REQ-020 SHALL drive out_addr from an address counter; +4 on each out_valid&&out_ready; wraps modulo 2^32.
REQ-021 SHALL reload counter to BASE_ADDR on clr_addr; clr_addr wins over a simultaneous pop.
REQ-022 SHALL increment err_cnt by 1 per accepted flagged input, saturating at all-ones.

Reset
REQ-023 SHALL on rst: count=0, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0, in_ready=1 (from next edge after release); mid-operation reset discards buffered words immediately.

Configuration
REQ-024 SHALL support macro INSTR_ENCODER_UJ_EN: defined -> U and J formats encoded per REQ-012/013; undefined -> fmt 4/5 treated as illegal per REQ-015 and U/J encode logic absent.

Structure
REQ-025 SHALL place format enum, opcode constants, and NOP constant in shared package rv_enc_pkg.
REQ-026 SHALL implement the buffer as sub-module enc_fifo2 (2-entry, width 33).

Verification
REQ-027 SHALL test I addi x1,x0,5 (op 0x13,f3 0,imm 5) -> out_instr 0x00500093, out_err 0, out_addr BASE_ADDR.
REQ-028 SHALL test S sw x2,8(x1) (op 0x23,f3 2) -> 0x0020A423; B beq x0,x0,-4 (op 0x63) -> 0xFE000EE3.
REQ-029 SHALL test I imm=2048 rd=1 op 0x13 -> 0x80000093, out_err 1, err_cnt 1; fmt 7 -> 0x00000013, err 1, err_cnt 2.
REQ-030 SHALL test out_ready=0 with 3 pushes -> in_ready low after 2nd accept, 3rd held; release -> words in order, out_addr 0,4,8.
REQ-031 SHALL test clr_addr concurrent with pop -> next out_addr BASE_ADDR; rst with 2 buffered -> out_valid 0 at once, err_cnt 0.
REQ-032 SHALL test with INSTR_ENCODER_UJ_EN: lui x5,0x12345 -> 0x123452B7; without: same stimulus -> 0x00000013, err 1.

Source files
------------

// File: rtl/rv_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_enc_pkg
// Purpose  : Shared definitions for the RV32I field-bundle encoder: the
//            instruction-format enum, major opcode constants, the canonical
//            NOP word and a sign-extension range helper.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package rv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_OP_IMM = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // FIFO entry = {err, instr}
  localparam int ENC_W = 33;

  // True when v[31:lsb] are all the same bit, i.e. v is representable as a
  // sign-extended (lsb+1)-bit quantity.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
    logic signed [31:0] s;
    s = $signed(v) >>> lsb;
    return (s == 32'sd0) || (s == -32'sd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : enc_fifo2
// Purpose  : Two-entry synchronous FIFO holding encoded words. Head data is
//            taken straight from storage so it is stable while not popped.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            push/push_data - write strobe and data (never asserted when full)
//            full           - both entries occupied
//            pop            - read strobe (never asserted when empty)
//            head/not_empty - oldest entry and its valid flag
// Revision : 1.0 - initial release
// ============================================================================
module enc_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full      = (r_count == 2'd2);
  assign not_empty = (r_count != 2'd0);
  assign head      = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs RV32I field bundles into 32-bit instruction words, flags
//            out-of-range immediates and illegal formats, buffers the words in
//            a 2-entry FIFO and tags each output word with a fetch address.
// Ports    : clk, rst                    - clock, async active-high reset
//            in_valid/in_ready           - field-bundle handshake
//            in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
//            in_imm                      - instruction fields
//            out_valid/out_ready         - encoded-word handshake
//            out_instr, out_err          - head word and its error flag
//            out_addr                    - address of the head word
//            clr_addr                    - synchronous address reload
//            err_cnt                     - saturating count of flagged inputs
// Config   : INSTR_ENCODER_UJ_EN - when defined, U and J formats are encoded;
//            otherwise format codes 4/5 are illegal and produce a flagged NOP.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  input  logic             clr_addr,
  output logic [ERR_W-1:0] err_cnt
);

  import rv_enc_pkg::*;

  logic [31:0]      w_instr;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [ENC_W-1:0] w_head;
  logic [31:0]      r_addr;
  logic [ERR_W-1:0] r_err_cnt;

  // Out-of-range immediates still produce the truncated encoding; only the
  // error flag distinguishes them.
  always_comb begin
    w_instr = NOP_INSTR;
    w_err   = 1'b1;
    case (in_fmt)
      FMT_R: begin
        w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_err   = 1'b0;
      end
      FMT_I: begin
        w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err   = ~sext_fits(in_imm, 11);
      end
      FMT_S: begin
        w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err   = ~sext_fits(in_imm, 11);
      end
      FMT_B: begin
        w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        w_err   = in_imm[0] | ~sext_fits(in_imm, 12);
      end
`ifdef INSTR_ENCODER_UJ_EN
      FMT_U: begin
        w_instr = {in_imm[31:12], in_rd, in_opcode};
        w_err   = |in_imm[11:0];
      end
      FMT_J: begin
        w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_err   = in_imm[0] | ~sext_fits(in_imm, 20);
      end
`endif
      default: begin
        w_instr = NOP_INSTR;
        w_err   = 1'b1;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready = ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  enc_fifo2 #(
    .WIDTH(ENC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({w_err, w_instr}),
    .full      (w_full),
    .pop       (w_pop),
    .head      (w_head),
    .not_empty (out_valid)
  );

  assign out_instr = w_head[31:0];
  assign out_err   = w_head[32];

  // Reload takes priority over the post-pop increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= BASE_ADDR;
    end else if (clr_addr) begin
      r_addr <= BASE_ADDR;
    end else if (w_pop) begin
      r_addr <= r_addr + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_push && w_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_addr = r_addr;
  assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
